fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side companion to the FIFO pointer controller. Drains a FIFO read port (read strobe plus `empty`, fixed read latency) and presents the data as a valid/ready stream.
- Uses an internal credit-controlled skid buffer, so it never over-reads and sustains 1 beat/cycle under continuous `m_ready`.
- Sits in the read clock domain between FIFO storage and downstream consumers.

Parameters:
- DATA_WIDTH, 8, width of FIFO read data and stream data.
- BUF_DEPTH, 2, skid buffer entries; power of 2, >= RD_LATENCY+1.
- RD_LATENCY, 1, cycles from `fifo_rd` to valid `fifo_rdata`; legal values 1 or 2.

Ports:
- `aclk`  in  1  read-domain clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `fifo_empty`  in  1  FIFO has no readable entry (underflow flag of the controller).
- `fifo_rd`  out  1  read strobe to FIFO; one entry per asserted cycle.
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after `fifo_rd`.
- `flush`  in  1  synchronous discard of buffered and in-flight data.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATA_WIDTH  stream data.
- `beat_count`  out  16  number of accepted beats, wraps.

Behaviour:
- Reset: asynchronous on `aresetn` low. Clears `m_valid`=0, `m_data`=0, `beat_count`=0, occupancy=0, pointers=0 and the latency pipe. `fifo_rd`=0 while `aresetn` is low.
- Storage: circular buffer of BUF_DEPTH entries.
  - `wptr`/`rptr` are $clog2(BUF_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - occ = `wptr` - `rptr`.
- `m_valid` = (occ != 0). `m_data` = buf[`rptr`].
  - Once `m_valid` is high, `m_data` is stable until accepted; the head entry is never overwritten.
- pop = `m_valid` & `m_ready`. On pop, `rptr` increments and `beat_count` increments (16'hFFFF wraps to 0).
- inflight = number of set bits in an RD_LATENCY-deep shift pipe fed by `fifo_rd`.
- Issue rule (combinational): `fifo_rd` = !`fifo_empty` & !`flush` & (occ + inflight - pop < BUF_DEPTH).
  - Combinational path from `m_ready` to `fifo_rd` is intentional, for full throughput.
- Capture:
  - When the pipe output bit is set in a cycle, `fifo_rdata` is written to buf[`wptr`] at that clock edge and `wptr` increments.
  - Timing: `fifo_rd` in cycle N, capture at end of cycle N+RD_LATENCY, `m_valid` high in cycle N+RD_LATENCY+1.
- Simultaneous capture and pop in the same cycle: both happen; occ unchanged.
- The issue rule guarantees capture never occurs while occ == BUF_DEPTH. An SVA checks this; there is no drop path.
- Buffer full (occ == BUF_DEPTH, no pop): `fifo_rd`=0 regardless of `fifo_empty`.
- `fifo_empty` high: no read issued. In-flight reads still complete and are captured.
- Flush cycle:
  - `fifo_rd` is forced 0.
  - At the edge, the pipe, occ and pointers are cleared; data arriving that cycle is discarded.
  - Any pop in the flush cycle still counts in `beat_count`; `beat_count` is otherwise unaffected.
  - `m_valid`=0 from the next cycle.
  - Reads issued before the flush are lost; FIFO pointers are not rewound.
- Reset mid-operation: immediate clear of all state; in-flight data is dropped.
- Pointer wrap: natural binary wrap of `wptr`/`rptr`; occ is computed modulo 2^(ptr width).

Decomposition:
- Package `fifo_pkg` contains:
  - BEAT_CNT_W = 16.
  - typedef `beat_cnt_t` (logic [BEAT_CNT_W-1:0]).
  - Function `ptr_w(depth)` returning $clog2(depth)+1.
- One sub-module, `fifo_rd_lat_pipe`. It is the RD_LATENCY-deep valid shift register with flush clear, and outputs the pipe tail bit and the inflight count.
- The buffer and counters stay in the top module.

Test Plan:
- Reset then idle, `fifo_empty`=1: `fifo_rd`=0, `m_valid`=0, `beat_count`=0 for 20 cycles.
- Streaming: FIFO holds 0x01..0x10, RD_LATENCY=1, `m_ready`=1. Expect first `fifo_rd` at cycle 0, `m_valid` at cycle 2, then 16 consecutive beats 0x01..0x10 with no bubbles; `beat_count`=16.
- Backpressure: `m_ready`=0 with FIFO non-empty. Expect exactly BUF_DEPTH (2) reads, then `fifo_rd` stays 0 and `m_data`=0x01 holds. Release `m_ready`: order 0x01,0x02,0x03 preserved, no loss or duplication.
- Empty mid-stream: `fifo_empty` rises after 3 reads with 1 in flight. Expect the in-flight beat delivered and no further `fifo_rd` until `fifo_empty` falls.
- Flush with occ=2 and 1 in flight (RD_LATENCY=2): `m_valid`=0 next cycle, the late `fifo_rdata` is ignored, next delivered beat comes from a fresh read, and `beat_count` is unchanged.
- Wrap: 65537 accepted beats → `beat_count`=1. `aresetn` pulse mid-stream clears `m_valid` and `beat_count` asynchronously.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream logic.
//   BEAT_CNT_W : width of the accepted-beat counter
//   beat_cnt_t : accepted-beat counter type
//   ptr_w()    : buffer pointer width, one extra MSB to tell full from empty
package fifo_pkg;

    localparam int BEAT_CNT_W = 16;

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_lat_pipe.sv
// Tracks reads that have been issued to the FIFO but whose data has not yet
// been captured. One bit per cycle of read latency.
//   aclk, aresetn : read-domain clock, async active-low reset
//   flush         : clears all tracked reads (their data will be discarded)
//   rd            : read strobe issued this cycle
//   tail          : read data is present on the FIFO data bus this cycle
//   inflight      : number of reads currently tracked
module fifo_rd_lat_pipe #(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = $clog2(RD_LATENCY + 1)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             rd,
    output logic             tail,
    output logic [CNT_W-1:0] inflight
);

    logic [RD_LATENCY-1:0] pipe_r;
    logic [RD_LATENCY-1:0] pipe_nxt_s;
    logic [CNT_W-1:0]      inflight_s;

    // Next pipe value: shift toward the tail, new strobe enters at bit 0.
    always_comb begin
        pipe_nxt_s    = pipe_r << 1'b1;
        pipe_nxt_s[0] = rd;
    end

    // Pipe register; flush forgets every outstanding read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_r <= '0;
        end else if (flush) begin
            pipe_r <= '0;
        end else begin
            pipe_r <= pipe_nxt_s;
        end
    end

    // Population count of the pipe, including the bit captured this cycle.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(pipe_r[i]);
        end
    end

    assign tail     = pipe_r[RD_LATENCY-1];
    assign inflight = inflight_s;

endmodule

// File: rtl/fifo_rd_stream_sva.sv
// Safety properties of the read-side skid buffer.
//   aclk, aresetn : read-domain clock, async active-low reset
//   cap           : buffer write this cycle
//   occ           : buffer occupancy
module fifo_rd_stream_sva #(
    parameter int PTR_W     = 2,
    parameter int BUF_DEPTH = 2
) (
    input logic             aclk,
    input logic             aresetn,
    input logic             cap,
    input logic [PTR_W-1:0] occ
);

    // The credit rule must keep a capture from ever landing on a full buffer,
    // which would overwrite the unread head entry.
    a_no_capture_when_full: assert property (
        @(posedge aclk) disable iff (!aresetn) cap |-> (occ != PTR_W'(BUF_DEPTH)));

    a_occ_bounded: assert property (
        @(posedge aclk) disable iff (!aresetn) occ <= PTR_W'(BUF_DEPTH));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a fixed-latency FIFO read port into a valid/ready stream through a
// credit-controlled skid buffer. Reads are only issued when the buffer is
// guaranteed room for the returning data, so nothing is ever dropped.
//   aclk, aresetn      : read-domain clock, async active-low reset
//   fifo_empty         : FIFO has nothing to read
//   fifo_rd            : read strobe to FIFO
//   fifo_rdata         : FIFO data, RD_LATENCY cycles after fifo_rd
//   flush              : discard buffered and in-flight data
//   m_valid/m_ready    : stream handshake
//   m_data             : stream data (head of the buffer)
//   beat_count         : accepted beats, wrapping
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output beat_cnt_t             beat_count
);

    localparam int PTR_W = ptr_w(BUF_DEPTH);
    localparam int IDX_W = PTR_W - 1;
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam int SUM_W = PTR_W + CNT_W + 1;

    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [DATA_WIDTH-1:0] buf_r [BUF_DEPTH];
    beat_cnt_t             beat_cnt_r;

    logic [PTR_W-1:0]      occ_s;
    logic                  valid_s;
    logic                  pop_s;
    logic                  cap_s;
    logic                  rd_s;
    logic                  tail_s;
    logic [CNT_W-1:0]      inflight_s;
    logic [SUM_W-1:0]      credit_s;

    fifo_rd_lat_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_lat_pipe (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .flush    (flush),
        .rd       (rd_s),
        .tail     (tail_s),
        .inflight (inflight_s)
    );

    // Occupancy, handshake and issue decision. Subtracting this cycle's pop
    // lets a read be issued in the same cycle a slot frees up, which is what
    // keeps a continuously-ready consumer at one beat per cycle.
    always_comb begin
        occ_s    = wptr_r - rptr_r;
        valid_s  = (occ_s != '0);
        pop_s    = valid_s & m_ready;
        cap_s    = tail_s & ~flush;
        credit_s = SUM_W'(occ_s) + SUM_W'(inflight_s) - SUM_W'(pop_s);
        if (!aresetn || flush || fifo_empty) begin
            rd_s = 1'b0;
        end else if (credit_s < SUM_W'(BUF_DEPTH)) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
    end

    // Buffer pointers and the accepted-beat counter. A pop during a flush
    // cycle still counts as delivered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_r     <= '0;
            rptr_r     <= '0;
            beat_cnt_r <= '0;
        end else begin
            if (pop_s) begin
                beat_cnt_r <= beat_cnt_r + beat_cnt_t'(1'b1);
            end
            if (flush) begin
                wptr_r <= '0;
                rptr_r <= '0;
            end else begin
                if (cap_s) begin
                    wptr_r <= wptr_r + PTR_W'(1'b1);
                end
                if (pop_s) begin
                    rptr_r <= rptr_r + PTR_W'(1'b1);
                end
            end
        end
    end

    // Buffer storage; the credit rule guarantees the slot written is free.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_r[i] <= '0;
            end
        end else if (cap_s) begin
            buf_r[wptr_r[IDX_W-1:0]] <= fifo_rdata;
        end
    end

    fifo_rd_stream_sva #(
        .PTR_W     (PTR_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_sva (
        .aclk    (aclk),
        .aresetn (aresetn),
        .cap     (cap_s),
        .occ     (occ_s)
    );

    assign fifo_rd    = rd_s;
    assign m_valid    = valid_s;
    assign m_data     = buf_r[rptr_r[IDX_W-1:0]];
    assign beat_count = beat_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream. Instance 0: RD_LATENCY=1, BUF_DEPTH=2.
// Instance 1: RD_LATENCY=2, BUF_DEPTH=4. A FIFO source model returns data
// with the configured latency; a reference queue holds every word read and
// not yet delivered or flushed, and each accepted beat must match its head.
module tb_fifo_rd_stream;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       fifo_empty [2];
    logic       fifo_rd    [2];
    logic [7:0] fifo_rdata [2];
    logic       flush      [2];
    logic       m_valid    [2];
    logic       m_ready    [2];
    logic [7:0] m_data     [2];
    logic [15:0] beat_count [2];

    logic [7:0] src_q [2][$];
    logic [7:0] exp_q [2][$];
    logic [7:0] pend [int];
    bit         force_empty [2];
    bit         prev_hold [2];
    logic [7:0] prev_data [2];
    longint     beats_m [2];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 aclk = ~aclk;

    fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(2), .RD_LATENCY(1)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn), .fifo_empty(fifo_empty[0]), .fifo_rd(fifo_rd[0]),
        .fifo_rdata(fifo_rdata[0]), .flush(flush[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_data(m_data[0]), .beat_count(beat_count[0]));

    fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(4), .RD_LATENCY(2)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .fifo_empty(fifo_empty[1]), .fifo_rd(fifo_rd[1]),
        .fifo_rdata(fifo_rdata[1]), .flush(flush[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_data(m_data[1]), .beat_count(beat_count[1]));

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int depth(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    // FIFO source: presents read data RD_LATENCY cycles after the strobe,
    // random garbage otherwise, and reports empty from its own queue.
    always @(posedge aclk) begin
        cyc = cyc + 1;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (pend.exists(cyc * 2 + k)) begin
                fifo_rdata[k] = pend[cyc * 2 + k];
                pend.delete(cyc * 2 + k);
            end else begin
                fifo_rdata[k] = 8'($urandom);
            end
            fifo_empty[k] = force_empty[k] || (src_q[k].size() == 0);
        end
    end

    // Reference model and stream monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (aresetn) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (beat_count[k] !== beats_m[k][15:0]) begin
                    n_fail++;
                    $display("FAIL beat_count[%0d]: got %0d expected %0d", k, beat_count[k], beats_m[k][15:0]);
                end
                if (prev_hold[k]) begin
                    n_checks++;
                    if (m_valid[k] !== 1'b1 || m_data[k] !== prev_data[k]) begin
                        n_fail++;
                        $display("FAIL hold[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, m_valid[k], m_data[k], prev_data[k]);
                    end
                end
                if (m_valid[k] && m_ready[k]) begin
                    n_checks++;
                    if (exp_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL beat[%0d]: got unexpected %h expected no beat", k, m_data[k]);
                    end else begin
                        if (m_data[k] !== exp_q[k][0]) begin
                            n_fail++;
                            $display("FAIL beat[%0d]: got %h expected %h", k, m_data[k], exp_q[k][0]);
                        end
                        void'(exp_q[k].pop_front());
                    end
                    beats_m[k]++;
                end
                if (fifo_rd[k] === 1'b1) begin
                    n_checks++;
                    if (fifo_empty[k] !== 1'b0 || src_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL read_when_empty[%0d]: got fifo_rd=1 expected 0", k);
                    end else begin
                        pend[(cyc + lat(k)) * 2 + k] = src_q[k][0];
                        exp_q[k].push_back(src_q[k].pop_front());
                    end
                end
                if (flush[k]) begin
                    n_checks++;
                    if (fifo_rd[k] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rd_in_flush[%0d]: got %b expected 0", k, fifo_rd[k]);
                    end
                    exp_q[k].delete();
                end
                n_checks++;
                if (exp_q[k].size() > depth(k)) begin
                    n_fail++;
                    $display("FAIL overread[%0d]: got %0d outstanding expected <= %0d", k, exp_q[k].size(), depth(k));
                end
                prev_hold[k] = m_valid[k] && !m_ready[k] && !flush[k];
                prev_data[k] = m_data[k];
            end
        end else begin
            prev_hold[0] = 1'b0;
            prev_hold[1] = 1'b0;
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic void clear_model();
        for (int k = 0; k < 2; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
            beats_m[k] = 0;
            prev_hold[k] = 1'b0;
        end
        pend.delete();
    endfunction

    task automatic test_reset();
        src_q[0].push_back(8'hAA);
        src_q[1].push_back(8'hBB);
        force_empty[0] = 1'b0;
        force_empty[1] = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (fifo_rd[k] !== 1'b0 || m_valid[k] !== 1'b0 || m_data[k] !== 8'h00 || beat_count[k] !== 16'd0) begin
                    n_fail++;
                    $display("FAIL in_reset[%0d]: got rd=%b valid=%b data=%h cnt=%0d expected all 0", k, fifo_rd[k], m_valid[k], m_data[k], beat_count[k]);
                end
            end
        end
        step();
        clear_model();
        force_empty[0] = 1'b1;
        force_empty[1] = 1'b1;
        step();
        aresetn = 1'b1;
        repeat (20) begin
            @(negedge aclk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (fifo_rd[k] !== 1'b0 || m_valid[k] !== 1'b0 || beat_count[k] !== 16'd0) begin
                    n_fail++;
                    $display("FAIL idle[%0d]: got rd=%b valid=%b cnt=%0d expected 0 0 0", k, fifo_rd[k], m_valid[k], beat_count[k]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        step();
        force_empty[0] = 1'b0;
        m_ready[0] = 1'b1;
        for (int i = 1; i <= 16; i++) src_q[0].push_back(8'(i));
        for (int c = 0; c <= 18; c++) begin
            @(negedge aclk);
            n_checks++;
            if (fifo_rd[0] !== ((c < 16) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL stream_rd c%0d: got %b expected %b", c, fifo_rd[0], (c < 16));
            end
            n_checks++;
            if (m_valid[0] !== ((c >= 2 && c <= 17) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: got %b expected %b", c, m_valid[0], (c >= 2 && c <= 17));
            end else if (c >= 2 && c <= 17 && m_data[0] !== 8'(c - 1)) begin
                n_fail++;
                $display("FAIL stream_data c%0d: got %h expected %h", c, m_data[0], 8'(c - 1));
            end
        end
        n_checks++;
        if (beat_count[0] !== 16'd16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 16", beat_count[0]);
        end
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        logic [7:0] got [$];
        step();
        m_ready[0] = 1'b0;
        src_q[0].push_back(8'h01);
        src_q[0].push_back(8'h02);
        src_q[0].push_back(8'h03);
        repeat (10) begin
            @(negedge aclk);
            if (fifo_rd[0]) rd_cnt++;
        end
        n_checks++;
        if (rd_cnt != 2 || fifo_rd[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_data[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL bp_stall: got reads=%0d rd=%b valid=%b data=%h expected 2 0 1 01", rd_cnt, fifo_rd[0], m_valid[0], m_data[0]);
        end
        step();
        m_ready[0] = 1'b1;
        repeat (8) begin
            @(negedge aclk);
            if (m_valid[0] && m_ready[0]) got.push_back(m_data[0]);
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03) begin
            n_fail++;
            $display("FAIL bp_order: got %0d beats %p expected 01 02 03", got.size(), got);
        end
    endtask

    task automatic test_empty_midstream();
        int rd_cnt = 0;
        int beats = 0;
        logic [7:0] last = 8'h00;
        bit ok = 1'b0;
        step();
        m_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) src_q[0].push_back(8'(8'h20 + i));
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge aclk);
            if (fifo_rd[0]) rd_cnt++;
            if (m_valid[0] && m_ready[0]) begin beats++; last = m_data[0]; end
            ok = (rd_cnt == 3);
        end
        step();
        force_empty[0] = 1'b1;
        repeat (8) begin
            @(negedge aclk);
            n_checks++;
            if (fifo_rd[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_rd: got %b expected 0", fifo_rd[0]);
            end
            if (m_valid[0] && m_ready[0]) begin beats++; last = m_data[0]; end
        end
        n_checks++;
        if (beats != 3 || last !== 8'h22) begin
            n_fail++;
            $display("FAIL empty_inflight: got %0d beats last %h expected 3 last 22", beats, last);
        end
        step();
        force_empty[0] = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (fifo_rd[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_resume: got %b expected 1", fifo_rd[0]);
        end
        for (int c = 0; c < 20 && beats < 6; c++) begin
            @(negedge aclk);
            if (m_valid[0] && m_ready[0]) begin beats++; last = m_data[0]; end
        end
        n_checks++;
        if (beats != 6 || last !== 8'h25) begin
            n_fail++;
            $display("FAIL empty_drain: got %0d beats last %h expected 6 last 25", beats, last);
        end
    endtask

    task automatic test_flush();
        int rd_cnt = 0;
        longint base;
        bit seen = 1'b0;
        logic [7:0] first = 8'h00;
        step();
        m_ready[1] = 1'b0;
        force_empty[1] = 1'b0;
        src_q[1].push_back(8'h40);
        src_q[1].push_back(8'h41);
        src_q[1].push_back(8'h42);
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            if (fifo_rd[1]) rd_cnt++;
        end
        n_checks++;
        if (rd_cnt != 3 || m_valid[1] !== 1'b1 || m_data[1] !== 8'h40) begin
            n_fail++;
            $display("FAIL flush_setup: got reads=%0d valid=%b data=%h expected 3 1 40", rd_cnt, m_valid[1], m_data[1]);
        end
        step();
        base = beats_m[1];
        src_q[1].push_back(8'h50);
        flush[1] = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (fifo_rd[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rd: got %b expected 0", fifo_rd[1]);
        end
        step();
        flush[1] = 1'b0;
        m_ready[1] = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (m_valid[1] !== 1'b0 || beat_count[1] !== base[15:0]) begin
            n_fail++;
            $display("FAIL flush_clear: got valid=%b cnt=%0d expected 0 %0d", m_valid[1], beat_count[1], base[15:0]);
        end
        for (int c = 0; c < 15 && !seen; c++) begin
            @(negedge aclk);
            if (m_valid[1] && m_ready[1]) begin seen = 1'b1; first = m_data[1]; end
        end
        n_checks++;
        if (!seen || first !== 8'h50) begin
            n_fail++;
            $display("FAIL flush_fresh: got seen=%b data=%h expected 1 50", seen, first);
        end
        @(negedge aclk);
        n_checks++;
        if (beat_count[1] !== 16'(base + 1)) begin
            n_fail++;
            $display("FAIL flush_count: got %0d expected %0d", beat_count[1], 16'(base + 1));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                m_ready[k] = ($urandom_range(0, 3) != 0);
                force_empty[k] = ($urandom_range(0, 5) == 0);
                flush[k] = ($urandom_range(0, 40) == 0);
                if (src_q[k].size() < 3) src_q[k].push_back(8'($urandom));
            end
        end
        step();
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0;
            force_empty[k] = 1'b1;
            m_ready[k] = 1'b1;
        end
        repeat (20) @(negedge aclk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (exp_q[k].size() != 0 || m_valid[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL random_drain[%0d]: got %0d pending valid=%b expected 0 0", k, exp_q[k].size(), m_valid[k]);
            end
            src_q[k].delete();
        end
    endtask

    task automatic test_reset_midstream();
        step();
        force_empty[0] = 1'b0;
        m_ready[0] = 1'b1;
        for (int i = 0; i < 16; i++) src_q[0].push_back(8'($urandom));
        repeat (6) step();
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (m_valid[0] !== 1'b0 || beat_count[0] !== 16'd0 || fifo_rd[0] !== 1'b0 || m_data[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b cnt=%0d rd=%b data=%h expected 0 0 0 00", m_valid[0], beat_count[0], fifo_rd[0], m_data[0]);
        end
        clear_model();
        force_empty[0] = 1'b1;
        m_ready[0] = 1'b0;
        step();
        step();
        aresetn = 1'b1;
    endtask

    task automatic test_wrap();
        int cnt = 0;
        bit done = 1'b0;
        step();
        for (int i = 0; i < 65537; i++) src_q[0].push_back(8'(i));
        force_empty[0] = 1'b0;
        m_ready[0] = 1'b1;
        for (int c = 0; c < 70000 && !done; c++) begin
            @(negedge aclk);
            if (m_valid[0] && m_ready[0]) cnt++;
            done = (cnt == 65537);
        end
        step();
        m_ready[0] = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (!done || beat_count[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL wrap: got beats=%0d cnt=%0d expected 65537 1", cnt, beat_count[0]);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = 1'b1;
            fifo_rdata[k] = 8'h00;
            flush[k] = 1'b0;
            m_ready[k] = 1'b0;
            force_empty[k] = 1'b1;
            beats_m[k] = 0;
            prev_hold[k] = 1'b0;
            prev_data[k] = 8'h00;
        end
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_midstream();
        test_flush();
        test_random();
        test_reset_midstream();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
